// File: rtl/baud_gen_frac.sv
// rtl/baud_gen_frac.sv - fractional baud-rate generator with preset/custom divisor and glitch-free reload
//
// Generates rx_tick (oversample strobe) and tx_tick (bit strobe, every OVS-th
// rx_tick) from a fixed-point divisor {int, frac}. The divisor comes from one
// of eight presets or from a custom runtime value. A new divisor is applied
// only at a tx_tick (or right away while disabled), so the TX bit in progress
// is never stretched or cut short.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   en                  generator enable
//   cfg_mode            0 = preset from bd_rate, 1 = custom div_int/div_frac
//   bd_rate             preset index (1200 .. 115200 baud)
//   div_int, div_frac   custom divisor, cycles per oversample period
//   cfg_load            one-cycle request to load a new divisor
//   resync              realign phase to mid-bit (RX start-bit edge)
//   rx_tick, tx_tick    one-cycle strobes
//   cfg_ack, cfg_err    one-cycle load status pulses
//   active_div          divisor currently in use, {int, frac}
module baud_gen_frac #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int OVS        = 16,
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = 4,
    parameter int RST_PRESET = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic                      cfg_mode,
    input  logic [2:0]                bd_rate,
    input  logic [DIV_W-1:0]          div_int,
    input  logic [FRAC_W-1:0]         div_frac,
    input  logic                      cfg_load,
    input  logic                      resync,
    output logic                      rx_tick,
    output logic                      tx_tick,
    output logic                      cfg_ack,
    output logic                      cfg_err,
    output logic [DIV_W+FRAC_W-1:0]   active_div
);

    localparam int DW   = DIV_W + FRAC_W;
    localparam int CW   = DIV_W + 1;
    localparam int PH_W = (OVS > 1) ? $clog2(OVS) : 1;

    function automatic longint rate_of(input int idx);
        case (idx)
            0:       return longint'(1200);
            1:       return longint'(2400);
            2:       return longint'(4800);
            3:       return longint'(9600);
            4:       return longint'(19200);
            5:       return longint'(38400);
            6:       return longint'(57600);
            default: return longint'(115200);
        endcase
    endfunction

    // round(CLK_FREQ * 2^FRAC_W / (rate * OVS)) done as (2x/d + 1) / 2
    function automatic logic [DW-1:0] calc_div(input longint rate);
        longint num;
        longint q;
        num = longint'(CLK_FREQ) * (longint'(1) << FRAC_W) * 2;
        q   = (num / (rate * longint'(OVS)) + 1) / 2;
        return q[DW-1:0];
    endfunction

    localparam logic [DW-1:0] PRESETS [8] = '{
        calc_div(rate_of(0)), calc_div(rate_of(1)), calc_div(rate_of(2)), calc_div(rate_of(3)),
        calc_div(rate_of(4)), calc_div(rate_of(5)), calc_div(rate_of(6)), calc_div(rate_of(7))
    };
    localparam logic [DW-1:0] RST_DIV = calc_div(rate_of(RST_PRESET));

    if (OVS < 2) begin : g_bad_ovs
        $error("baud_gen_frac: OVS must be >= 2");
    end
    if (RST_PRESET < 0 || RST_PRESET > 7) begin : g_bad_rst
        $error("baud_gen_frac: RST_PRESET must be 0..7");
    end
    for (genvar gi = 0; gi < 8; gi++) begin : g_chk_preset
        if (calc_div(rate_of(gi)) < DW'(2 << FRAC_W)) begin : g_bad
            $error("baud_gen_frac: preset integer divisor below 2");
        end
    end

    logic [DW-1:0]     r_div;       // divisor driving the counters
    logic [DW-1:0]     r_active;    // reported divisor, trails r_div by one cycle
    logic [DW-1:0]     r_pend_div;
    logic              r_pend;
    logic              r_applied;
    logic              r_run;       // low on the enabling edge so the first period is a full L_0
    logic [CW-1:0]     r_cnt;
    logic [FRAC_W-1:0] r_acc;
    logic [PH_W-1:0]   r_phase;
    logic              r_rx_tick;
    logic              r_tx_tick;
    logic              r_cfg_ack;
    logic              r_cfg_err;

    logic [DIV_W-1:0]  w_int;
    logic [FRAC_W-1:0] w_frac;
    logic [FRAC_W:0]   w_sum;
    logic [CW-1:0]     w_last;
    logic              w_wrap;
    logic              w_phase_end;
    logic              w_tx;
    logic              w_apply;
    logic [DW-1:0]     w_cand;
    logic              w_cand_bad;
    logic              w_load_ok;

    assign w_int       = r_div[DW-1:FRAC_W];
    assign w_frac      = r_div[FRAC_W-1:0];
    assign w_sum       = {1'b0, r_acc} + {1'b0, w_frac};
    // period length is int plus the accumulator carry; counter runs 0..L-1
    assign w_last      = {1'b0, w_int} + CW'(w_sum[FRAC_W]) - CW'(1);
    assign w_wrap      = en && r_run && !resync && (r_cnt == w_last);
    assign w_phase_end = (r_phase == PH_W'(OVS - 1));
    assign w_tx        = w_wrap && w_phase_end;
    assign w_apply     = r_pend && (w_tx || !en);
    assign w_cand      = cfg_mode ? {div_int, div_frac} : PRESETS[bd_rate];
    assign w_cand_bad  = cfg_mode && (div_int < DIV_W'(2));
    assign w_load_ok   = cfg_load && !w_cand_bad;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div      <= RST_DIV;
            r_active   <= RST_DIV;
            r_pend_div <= '0;
            r_pend     <= 1'b0;
            r_applied  <= 1'b0;
            r_run      <= 1'b0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_phase    <= '0;
            r_rx_tick  <= 1'b0;
            r_tx_tick  <= 1'b0;
            r_cfg_ack  <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_active  <= r_div;
            r_applied <= w_apply;
            r_cfg_ack <= r_applied;
            r_cfg_err <= cfg_load && w_cand_bad;

            // a load landing on an application point queues behind the one applied
            if (w_load_ok) begin
                r_pend     <= 1'b1;
                r_pend_div <= w_cand;
            end else if (w_apply) begin
                r_pend <= 1'b0;
            end
            if (w_apply) begin
                r_div <= r_pend_div;
            end

            if (!en) begin
                r_run     <= 1'b0;
                r_cnt     <= '0;
                r_acc     <= '0;
                r_phase   <= '0;
                r_rx_tick <= 1'b0;
                r_tx_tick <= 1'b0;
            end else if (resync) begin
                r_run     <= 1'b1;
                r_cnt     <= '0;
                r_acc     <= '0;
                r_phase   <= PH_W'(OVS / 2);
                r_rx_tick <= 1'b0;
                r_tx_tick <= 1'b0;
            end else if (!r_run) begin
                r_run     <= 1'b1;
                r_rx_tick <= 1'b0;
                r_tx_tick <= 1'b0;
            end else if (w_wrap) begin
                r_cnt     <= '0;
                r_rx_tick <= 1'b1;
                r_tx_tick <= w_phase_end;
                r_phase   <= w_phase_end ? '0 : r_phase + PH_W'(1);
                // a newly applied divisor starts with a clean accumulator
                r_acc     <= w_apply ? '0 : w_sum[FRAC_W-1:0];
            end else begin
                r_cnt     <= r_cnt + CW'(1);
                r_rx_tick <= 1'b0;
                r_tx_tick <= 1'b0;
            end
        end
    end

    assign rx_tick    = r_rx_tick;
    assign tx_tick    = r_tx_tick;
    assign cfg_ack    = r_cfg_ack;
    assign cfg_err    = r_cfg_err;
    assign active_div = r_active;

endmodule

// File: tb/tb_baud_gen_frac.sv
// tb/tb_baud_gen_frac.sv - self-checking bench for baud_gen_frac
module tb_baud_gen_frac;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        en       = 1'b0;
    logic        cfg_mode = 1'b0;
    logic        cfg_load = 1'b0;
    logic        resync   = 1'b0;
    logic [2:0]  bd_rate  = 3'd0;
    logic [15:0] div_int  = 16'd0;
    logic [3:0]  div_frac = 4'd0;

    logic        a_rx, a_tx, a_ack, a_err;
    logic [19:0] a_div;
    logic        b_rx, b_tx, b_ack, b_err;
    logic [19:0] b_div;

    always #5 clk = ~clk;

    baud_gen_frac #(.CLK_FREQ(50_000_000), .OVS(4), .DIV_W(16), .FRAC_W(4), .RST_PRESET(3)) u_a (
        .clk(clk), .reset_n(reset_n), .en(en), .cfg_mode(cfg_mode), .bd_rate(bd_rate),
        .div_int(div_int), .div_frac(div_frac), .cfg_load(cfg_load), .resync(resync),
        .rx_tick(a_rx), .tx_tick(a_tx), .cfg_ack(a_ack), .cfg_err(a_err), .active_div(a_div)
    );

    baud_gen_frac #(.CLK_FREQ(50_000_000), .OVS(16), .DIV_W(16), .FRAC_W(4), .RST_PRESET(3)) u_b (
        .clk(clk), .reset_n(reset_n), .en(en), .cfg_mode(cfg_mode), .bd_rate(bd_rate),
        .div_int(div_int), .div_frac(div_frac), .cfg_load(cfg_load), .resync(resync),
        .rx_tick(b_rx), .tx_tick(b_tx), .cfg_ack(b_ack), .cfg_err(b_err), .active_div(b_div)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int orphan  = 0;

    typedef struct {
        logic       mode;
        logic [2:0] rate;
        int         di;
        int         df;
        logic       err;
        int         exp_a;
        int         exp_b;
    } cfg_vec_t;

    cfg_vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load(input logic m, input logic [2:0] r, input int di, input int df);
        cfg_mode = m;
        bd_rate  = r;
        div_int  = di[15:0];
        div_frac = df[3:0];
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
    endtask

    // steps until the selected instance shows rx_tick; returns its cycle or -1
    task automatic wait_tick(input int sel, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            step();
            if ((a_tx && !a_rx) || (b_tx && !b_rx)) orphan++;
            if ((sel == 0) ? a_rx : b_rx) begin
                at = cyc;
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL tick timeout: got none within %0d cycles expected a tick", limit);
    endtask

    // closed-form time of the j-th rx_tick after the enabling edge
    function automatic int model_tick(input int j, input int di, input int df);
        return j * di + ((j * df) >> 4);
    endfunction

    initial begin
        int t [0:48];
        logic txf [0:48];
        int c0, c, c2, c3, c_tx, t1, d, di, df;
        logic bad;

        vecs[0] = '{1'b0, 3'd7, 0, 0,     1'b0, 1736,    434};
        vecs[1] = '{1'b1, 3'd0, 6, 0,     1'b0, 96,      96};
        vecs[2] = '{1'b1, 3'd0, 1, 15,    1'b1, 96,      96};
        vecs[3] = '{1'b0, 3'd0, 0, 0,     1'b0, 166667,  41667};
        vecs[4] = '{1'b1, 3'd0, 0, 3,     1'b1, 166667,  41667};
        vecs[5] = '{1'b0, 3'd5, 0, 0,     1'b0, 5208,    1302};
        vecs[6] = '{1'b1, 3'd0, 65535, 15, 1'b0, 1048575, 1048575};
        vecs[7] = '{1'b1, 3'd0, 2, 0,     1'b0, 32,      32};
        vecs[8] = '{1'b0, 3'd3, 0, 0,     1'b0, 20833,   5208};

        // reset state
        step();
        step();
        check("reset a rx", a_rx, 0);
        check("reset a tx", a_tx, 0);
        check("reset a ack", a_ack, 0);
        check("reset a err", a_err, 0);
        check("reset a div", a_div, 20833);
        check("reset b div", b_div, 5208);
        reset_n = 1'b1;
        step();

        // configuration table, applied while disabled
        for (int i = 0; i < 9; i++) begin
            load(vecs[i].mode, vecs[i].rate, vecs[i].di, vecs[i].df);
            check($sformatf("vec%0d a err", i), a_err, vecs[i].err);
            check($sformatf("vec%0d b err", i), b_err, vecs[i].err);
            step();
            step();
            check($sformatf("vec%0d a ack", i), a_ack, !vecs[i].err);
            check($sformatf("vec%0d b ack", i), b_ack, !vecs[i].err);
            check($sformatf("vec%0d a div", i), a_div, vecs[i].exp_a);
            check($sformatf("vec%0d b div", i), b_div, vecs[i].exp_b);
            step();
            check($sformatf("vec%0d a ack single", i), a_ack, 0);
        end

        // preset 7 at OVS 16
        load(1'b0, 3'd7, 0, 0);
        step();
        step();
        check("preset7 b div", b_div, 434);
        en = 1'b1;
        c0 = cyc;
        t[0] = c0 + 1;
        for (int j = 1; j <= 48; j++) begin
            wait_tick(1, 40, t[j]);
            txf[j] = b_tx;
        end
        check("preset7 16 rx periods", t[16] - t[0], 434);
        check("preset7 tx at 16", txf[16], 1);
        check("preset7 no tx at 15", txf[15], 0);
        d = t[32] - t[16];
        check("preset7 tx period 1", (d >= 433 && d <= 435), 1);
        d = t[48] - t[32];
        check("preset7 tx period 2", (d >= 433 && d <= 435), 1);
        en = 1'b0;
        step();

        // custom {4,8} at OVS 4: periods alternate 4,5
        load(1'b1, 3'd0, 4, 8);
        step();
        step();
        en = 1'b1;
        c0 = cyc;
        t[0] = c0 + 1;
        for (int j = 1; j <= 16; j++) begin
            wait_tick(0, 20, t[j]);
            txf[j] = a_tx;
        end
        for (int j = 1; j <= 16; j++) begin
            check($sformatf("frac period %0d", j), t[j] - t[j-1], (j % 2 == 1) ? 4 : 5);
            check($sformatf("frac tx flag %0d", j), txf[j], (j % 4 == 0));
        end
        check("frac 16 periods", t[16] - t[0], 72);
        check("frac tx period", t[12] - t[8], 18);

        // mid-bit load of {6,0}: held until the next tx_tick
        wait_tick(0, 20, c);
        step();
        load(1'b1, 3'd0, 6, 0);
        bad  = 1'b0;
        c_tx = -1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (a_tx) begin
                c_tx = cyc;
                break;
            end
            if (a_ack || a_div != 20'd72) bad = 1'b1;
        end
        check("reload no early change", bad, 0);
        check("reload tx found", c_tx >= 0, 1);
        check("reload ack not at tx", a_ack, 0);
        check("reload div old at tx", a_div, 72);
        step();
        check("reload ack", a_ack, 1);
        check("reload div new", a_div, 96);
        step();
        check("reload ack single", a_ack, 0);
        wait_tick(0, 20, t1);
        check("reload first period", t1 - c_tx, 6);

        // invalid custom {1,15}
        load(1'b1, 3'd0, 1, 15);
        check("bad load err", a_err, 1);
        check("bad load div", a_div, 96);
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (a_ack || a_err || a_div != 20'd96) bad = 1'b1;
        end
        check("bad load quiet", bad, 0);

        // resync on the cycle a tick is due, {4,0}
        en = 1'b0;
        step();
        load(1'b1, 3'd0, 4, 0);
        step();
        step();
        en = 1'b1;
        wait_tick(0, 20, c);
        step();
        step();
        step();
        resync = 1'b1;
        step();
        check("resync suppress rx", a_rx, 0);
        check("resync suppress tx", a_tx, 0);
        resync = 1'b0;
        wait_tick(0, 20, c2);
        check("resync next rx", c2 - (c + 4), 4);
        check("resync first no tx", a_tx, 0);
        wait_tick(0, 20, c3);
        check("resync second period", c3 - c2, 4);
        check("resync tx after ovs/2", a_tx, 1);

        // reset while a request is pending
        load(1'b1, 3'd0, 7, 0);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst a rx", a_rx, 0);
        check("rst a tx", a_tx, 0);
        check("rst a ack", a_ack, 0);
        check("rst a err", a_err, 0);
        check("rst a div", a_div, 20833);
        check("rst b div", b_div, 5208);
        en = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (a_rx || a_tx || a_ack || b_rx || b_tx || b_ack || a_div != 20'd20833) bad = 1'b1;
        end
        check("post reset quiet", bad, 0);

        // randomized custom divisors against the closed-form schedule
        for (int r = 0; r < 8; r++) begin
            en = 1'b0;
            step();
            di = int'($urandom_range(2, 7));
            df = int'($urandom_range(0, 15));
            load(1'b1, 3'd0, di, df);
            step();
            step();
            check($sformatf("rnd%0d div", r), a_div, di * 16 + df);
            en = 1'b1;
            c0 = cyc;
            for (int j = 1; j <= 12; j++) begin
                wait_tick(0, 20, c);
                check($sformatf("rnd%0d tick%0d time", r, j), c - (c0 + 1), model_tick(j, di, df));
                check($sformatf("rnd%0d tick%0d tx", r, j), a_tx, (j % 4 == 0));
            end
        end

        check("tx without rx", orphan, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/baud_gen_frac.md
Name: baud_gen_frac

Overview:
- Parametrised fractional baud-rate generator, successor to the fixed 4-rate divider.
- Produces a one-cycle oversample strobe (rx_tick) for the UART receiver and a one-cycle bit strobe (tx_tick) for the transmitter.
- Divisor comes from 8 elaboration-time presets or a runtime fixed-point value; runtime changes are applied glitch-free at TX bit boundaries.
- Sits between the register/config interface and the uart_tx/uart_rx blocks.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz, used only to compute the presets.
- OVS, 16: oversample ratio, i.e. rx_ticks per tx_tick; must be >= 2.
- DIV_W, 16: integer divisor width.
- FRAC_W, 4: fractional divisor width.
- RST_PRESET, 3: preset index loaded at reset (9600 baud).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  generator enable.
- cfg_mode  in  1  0 = preset from bd_rate; 1 = custom from div_int/div_frac.
- bd_rate  in  3  preset index: 0..7 = 1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200 baud.
- div_int  in  DIV_W  custom integer divisor, in clk cycles per oversample period.
- div_frac  in  FRAC_W  custom fractional divisor, in units of 1/2^FRAC_W cycle.
- cfg_load  in  1  single-cycle request to load a new divisor.
- resync  in  1  realign phase; RX drives it on start-bit edge detection.
- rx_tick  out  1  one-cycle oversample strobe.
- tx_tick  out  1  one-cycle bit strobe, coincident with every OVS-th rx_tick.
- cfg_ack  out  1  one-cycle pulse: pending divisor has been applied.
- cfg_err  out  1  one-cycle pulse: load request rejected.
- active_div  out  DIV_W+FRAC_W  currently applied divisor as {int, frac}.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values:
  - rx_tick, tx_tick, cfg_ack, cfg_err = 0.
  - Cycle counter, phase counter, fraction accumulator and pending flag = 0.
  - active_div = preset RST_PRESET.
- Presets:
  - Computed at elaboration as div_fx = round(CLK_FREQ * 2^FRAC_W / (rate * OVS)), split into {int, frac}.
  - Example: CLK_FREQ = 50 MHz, 115200 baud gives 434 = {27, 2}.
  - Presets with int < 2 are an elaboration error.
- Period generation:
  - Period k has length L_k = int + c_k, where c_k is the carry out of (acc + frac), FRAC_W bits wide.
  - At each period end: acc <= (acc + frac) mod 2^FRAC_W.
  - The cycle counter runs 0..L_k-1. rx_tick is registered and high for exactly one cycle after the counter wraps.
  - Long-run average period is int + frac/2^FRAC_W cycles.
- Phase counter:
  - Counts rx_ticks modulo OVS.
  - tx_tick is asserted in the same cycle as the rx_tick that wraps phase from OVS-1 to 0.
  - The first tx_tick after enable coincides with the OVS-th rx_tick.
- Enable:
  - en = 0 holds the cycle counter, phase counter and accumulator at 0, and holds the ticks low.
  - The first rx_tick is asserted L_0 cycles after the first edge that samples en = 1.
- Resync:
  - Clears the cycle counter and the accumulator.
  - Sets phase to OVS/2, so the next tx-boundary-equivalent point falls mid-bit for RX.
  - Suppresses any tick that would occur in the same cycle; resync wins.
- Configuration load:
  - cfg_load captures the candidate divisor: the preset for bd_rate if cfg_mode = 0, else {div_int, div_frac}.
  - Custom int < 2: cfg_err pulses the next cycle, the request is discarded, and any existing pending request is unaffected.
  - Valid candidate: written to the pending register and the pending flag is set. A new cfg_load while pending overwrites the candidate; no ack is given for the overwritten one.
  - Application point: the pending divisor is applied on the cycle tx_tick is asserted, or on the next cycle if en = 0. On application, the counters and accumulator restart from 0 with the new divisor.
  - cfg_ack pulses the cycle after application; active_div updates in the same cycle as the ack.
  - cfg_load in the same cycle as an application point: the old pending divisor is applied, and the new request becomes pending.
- Arithmetic widths:
  - Cycle counter is DIV_W+1 bits, to hold int+1 without overflow.
  - int = 2^DIV_W-1 with a carry must count correctly.
- Reset mid-operation: all state returns to reset values immediately. A pending request is lost and no ack is issued.

Test Plan:
- Custom {int 4, frac 8}, FRAC_W 4, OVS 4, en = 1 -> rx_tick periods alternate 4, 5, 4, 5; tx_tick every 18 cycles; 16 periods total exactly 72 cycles.
- Preset 7, CLK_FREQ 50e6, OVS 16 -> active_div = {27, 2}; 16 rx periods total 434 cycles; tx_tick period 434 ± 1 cycles.
- cfg_load custom {6, 0} mid-bit, en = 1 -> no change until the next tx_tick; the following period is 6 cycles; cfg_ack one cycle after application; active_div = {6, 0}.
- cfg_load custom {1, 15} -> cfg_err pulse the next cycle; active_div unchanged; no cfg_ack.
- resync asserted in the same cycle an rx_tick is due, with {4, 0} -> no tick that cycle; next rx_tick 4 cycles after resync; tx_tick after OVS/2 more rx_ticks.
- reset_n low while a request is pending and en = 1 -> all outputs 0, active_div = preset 3 asynchronously; after release with en = 0, no ticks and no cfg_ack.
